// File: rtl/bp_me_clint_timer.sv
// CLINT-style timer block: mipi, mtimecmp and mtime registers behind a
// single-outstanding request/response port, plus software and timer interrupts.
module bp_me_clint_timer #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     rtc_tick_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [paddr_width_p-1:0] addr_i,
  input  logic [data_width_p-1:0]  data_i,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [data_width_p-1:0]  data_o,
  output logic                     err_o,
  output logic                     software_irq_o,
  output logic                     timer_irq_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [paddr_width_p-1:0] ADDR_MIPI     = paddr_width_p'(32'h0030_0000);
  localparam logic [paddr_width_p-1:0] ADDR_MTIMECMP = paddr_width_p'(32'h0030_4000);
  localparam logic [paddr_width_p-1:0] ADDR_MTIME    = paddr_width_p'(32'h0030_BFF8);

  logic [0:0]              r_state;
  logic                    r_mipi;
  logic [data_width_p-1:0] r_mtimecmp;
  logic [data_width_p-1:0] r_mtime;
  logic                    r_tick;
  logic                    r_timer_irq;
  logic [data_width_p-1:0] r_data;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_hit_mipi;
  logic                    w_hit_mtimecmp;
  logic                    w_hit_mtime;
  logic                    w_err;
  logic                    w_tick_edge;
  logic [data_width_p-1:0] w_rdata;

  assign ready_o        = (r_state == ST_IDLE);
  assign v_o            = (r_state == ST_RESP);
  assign data_o         = r_data;
  assign err_o          = r_err;
  assign software_irq_o = r_mipi;
  assign timer_irq_o    = r_timer_irq;

  assign w_accept       = v_i & ready_o;
  // Exact full-width compares also reject any misaligned byte address.
  assign w_hit_mipi     = (addr_i == ADDR_MIPI);
  assign w_hit_mtimecmp = (addr_i == ADDR_MTIMECMP);
  assign w_hit_mtime    = (addr_i == ADDR_MTIME);
  assign w_err          = ~(w_hit_mipi | w_hit_mtimecmp | w_hit_mtime);
  assign w_tick_edge    = rtc_tick_i & ~r_tick;

  always_comb begin
    // NOTE: default first so every path assigns w_rdata and no latch is inferred.
    w_rdata = '0;
    if (w_hit_mipi)     w_rdata = {{(data_width_p-1){1'b0}}, r_mipi};
    if (w_hit_mtimecmp) w_rdata = r_mtimecmp;
    if (w_hit_mtime)    w_rdata = r_mtime;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= ST_IDLE;
      r_mipi      <= 1'b0;
      r_mtimecmp  <= '1;
      r_mtime     <= '0;
      r_tick      <= 1'b0;
      r_timer_irq <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every compare below sees pre-edge state.
      r_tick      <= rtc_tick_i;
      r_timer_irq <= (r_mtime >= r_mtimecmp);
      if (w_tick_edge) r_mtime <= r_mtime + data_width_p'(1);

      if (w_accept) begin
        r_state <= ST_RESP;
        r_err   <= w_err;
        r_data  <= (w_i | w_err) ? '0 : w_rdata;
        if (w_i && !w_err) begin
          if (w_hit_mipi)     r_mipi     <= data_i[0];
          if (w_hit_mtimecmp) r_mtimecmp <= data_i;
          // NOTE: last non-blocking write wins, so a software mtime write discards a same-cycle tick.
          if (w_hit_mtime)    r_mtime    <= data_i;
        end
      end else if ((r_state == ST_RESP) && yumi_i) begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: doc/bp_me_clint_timer.md
BP_ME_CLINT_TIMER -- requirements
Module: bp_me_clint_timer

Interface
REQ-001 SHALL have parameter paddr_width_p, default 40, physical request address width.
REQ-002 SHALL have parameter data_width_p, default 64, request/response data width; only 64 supported.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port rtc_tick_i  input  1  real-time tick, already in clk_i domain.
REQ-006 SHALL have port v_i  input  1  request valid.
REQ-007 SHALL have port ready_o  output  1  block can accept request.
REQ-008 SHALL have port w_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port addr_i  input  paddr_width_p  request byte address.
REQ-010 SHALL have port data_i  input  data_width_p  write data.
REQ-011 SHALL have port v_o  output  1  response valid.
REQ-012 SHALL have port yumi_i  input  1  consumer takes response.
REQ-013 SHALL have port data_o  output  data_width_p  read data; 0 for writes and errors.
REQ-014 SHALL have port err_o  output  1  response error flag, valid with v_o.
REQ-015 SHALL have port software_irq_o  output  1  machine software interrupt.
REQ-016 SHALL have port timer_irq_o  output  1  machine timer interrupt.

Function
REQ-017 SHALL hold three registers: mipi (1b), mtimecmp (64b), mtime (64b).
REQ-018 SHALL decode full addr_i, zero-extended: 0x30_0000 = mipi, 0x30_4000 = mtimecmp, 0x30_BFF8 = mtime.
REQ-019 SHALL flag err for any other address or addr_i[2:0] != 0; erroring writes change no state; erroring reads return 0.
REQ-020 SHALL implement FSM states IDLE, RESP; IDLE->RESP on v_i & ready_o; RESP->IDLE on yumi_i.
REQ-021 SHALL drive ready_o = 1 only in IDLE, v_o = 1 only in RESP; one request outstanding max.
REQ-022 SHALL present response exactly one cycle after acceptance; data_o/err_o held stable while v_o & ~yumi_i.
REQ-023 SHALL capture read data in acceptance cycle (pre-update mtime value); mipi reads return {63'b0, mipi}.
REQ-024 SHALL apply writes in acceptance cycle, visible in registers from next cycle; mipi takes data_i[0].
REQ-025 SHALL register rtc_tick_i and increment mtime by 1 on each rising edge (tick_r == 0, rtc_tick_i == 1); a held-high tick counts once.
REQ-026 SHALL wrap mtime from 0xFFFF_FFFF_FFFF_FFFF to 0 without error.
REQ-027 SHALL let a mtime write win over a same-cycle tick increment (increment discarded).
REQ-028 SHALL drive timer_irq_o registered: value in cycle n+1 = (mtime >= mtimecmp, unsigned) in cycle n.
REQ-029 SHALL drive software_irq_o = mipi register directly.
REQ-030 SHALL ignore v_i while in RESP (no acceptance, no state change from request fields).

Reset
REQ-031 SHALL, on reset_n_i == 0 at a clock edge, set FSM IDLE, mipi 0, mtime 0, mtimecmp all-ones, tick_r 0, timer_irq_o 0, v_o 0, err_o 0, data_o 0.
REQ-032 SHALL drop any pending response and in-flight request on reset mid-operation; ready_o = 1 the first cycle after reset deasserts.
REQ-033 SHALL ignore rtc_tick_i and v_i during reset.

Verification
REQ-034 Reset then read 0x30_BFF8 -> v_o next cycle, data_o 0, err_o 0; read 0x30_4000 -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-035 Write mtimecmp=5, pulse rtc_tick_i 5 times -> timer_irq_o rises 1 cycle after mtime reaches 5; write mtimecmp=100 -> timer_irq_o 0 next-but-one cycle.
REQ-036 Write mtime=0xFFFF_FFFF_FFFF_FFFF, one tick -> read returns 0; write mtime=7 same cycle as tick edge -> read returns 7.
REQ-037 Write mipi=0x3 -> software_irq_o 1, read returns 1; write 0 -> software_irq_o 0.
REQ-038 Read 0x30_0004 and write 0x30_8000 -> err_o 1, data_o 0, no register changes; hold yumi_i low 4 cycles -> v_o/data_o stable, ready_o 0, extra v_i ignored.
REQ-039 Accept write mtimecmp, assert reset_n_i=0 before yumi_i -> v_o 0, mtimecmp all-ones after reset.
